// File: rtl/pulse_stretch_led_if.sv
// pulse_stretch_led_if: pulse input and LED/status outputs of pulse_stretch_led.
// master = the side that drives ttl_in (board / bench), slave = the stretcher.
interface pulse_stretch_led_if;
    logic ttl_in;
    logic led_out;
    logic busy;
    logic overflow;

    modport master (
        output ttl_in,
        input  led_out,
        input  busy,
        input  overflow
    );

    modport slave (
        input  ttl_in,
        output led_out,
        output busy,
        output overflow
    );
endinterface

// File: rtl/pulse_stretch_led.sv
// pulse_stretch_led: measures the width of a high pulse on the asynchronous
// ttl_in and replays it on led_out for width*SCALE clk cycles.
// Optional glitch filter: define PULSE_STRETCH_GLITCH_FILTER_EN to drop
// pulses shorter than MIN_PULSE synchronized cycles.
module pulse_stretch_led #(
    parameter int unsigned SCALE     = 100,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MIN_PULSE = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    pulse_stretch_led_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_WAIT     = 2'd0,
        ST_COUNTING = 2'd1,
        ST_SHOWING  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SCALE_C = CNT_W'(SCALE);
    localparam logic [CNT_W:0]   SCALE_X = (CNT_W+1)'(SCALE);

    // Reject configurations that would never stretch anything.
    if (SCALE < 1 || MIN_PULSE < 1) begin : g_bad_cfg
        $error("pulse_stretch_led: SCALE and MIN_PULSE must be >= 1");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             overflow;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W:0]   sum;

`ifdef PULSE_STRETCH_GLITCH_FILTER_EN
    localparam int unsigned       GLEN_W   = $clog2(MIN_PULSE + 1);
    localparam logic [GLEN_W-1:0] GLEN_MAX = GLEN_W'(MIN_PULSE);
    logic [GLEN_W-1:0] glen;
`endif

    assign rise = s2 & ~s3;
    // one spare bit so the carry out flags saturation
    assign sum  = {1'b0, cnt} + SCALE_X;

    // 2-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.ttl_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // measure / replay state machine with its counter and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_WAIT;
            cnt      <= '0;
            overflow <= 1'b0;
`ifdef PULSE_STRETCH_GLITCH_FILTER_EN
            glen     <= '0;
`endif
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt <= '0;
`ifdef PULSE_STRETCH_GLITCH_FILTER_EN
                    glen <= '0;
`endif
                    if (rise) begin
                        state    <= ST_COUNTING;
                        cnt      <= SCALE_C;
                        overflow <= 1'b0;
`ifdef PULSE_STRETCH_GLITCH_FILTER_EN
                        glen     <= GLEN_W'(1);
`endif
                    end
                end
                ST_COUNTING: begin
                    if (s2) begin
                        if (sum[CNT_W]) begin
                            cnt      <= '1;
                            overflow <= 1'b1;
                        end else begin
                            cnt <= sum[CNT_W-1:0];
                        end
`ifdef PULSE_STRETCH_GLITCH_FILTER_EN
                        if (glen < GLEN_MAX) begin
                            glen <= glen + 1'b1;
                        end
`endif
                    end else begin
`ifdef PULSE_STRETCH_GLITCH_FILTER_EN
                        if (glen < GLEN_MAX) begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end else begin
                            state <= ST_SHOWING;
                        end
`else
                        state <= ST_SHOWING;
`endif
                    end
                end
                ST_SHOWING: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.led_out  = (state == ST_SHOWING);
    assign bus.busy     = (state != ST_WAIT);
    assign bus.overflow = overflow;

endmodule
